// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin packet arbiter driving a shared 16:1 mux select
module mux16_rr_arbiter #(
  parameter int DATA_W = 8,
  parameter int NUM_REQ = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [3:0]                sel,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [3:0] ptr, arb_ptr, win;
  logic [NUM_REQ-1:0] rot;
  logic found, done;
  assign busy = state == LOCKED;
  assign arb_ptr = busy ? sel + 4'd1 : ptr;
  assign rot = NUM_REQ'({req_valid, req_valid} >> arb_ptr);
  assign found = |req_valid;
  always_comb begin
    win = arb_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) win = rot[i] ? arb_ptr + 4'(i) : win;
  end
  assign out_valid = busy & req_valid[sel];
  assign out_data = req_data[sel*DATA_W +: DATA_W];
  assign out_last = req_last[sel];
  assign req_ready = busy & out_ready ? NUM_REQ'(1) << sel : '0;
  assign done = out_valid & out_ready & out_last;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      grant <= '0;
      ptr <= '0;
    end else if (!busy || done) begin
      ptr <= busy ? sel + 4'd1 : ptr;
      state <= found ? LOCKED : IDLE;
      sel <= found ? win : sel;
      grant <= found ? NUM_REQ'(1) << win : '0;
    end
  end
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: directed plus random checks of the arbiter against a behavioural model
module tb_mux16_rr_arbiter;
  localparam int DW = 8;
  logic clk = 0, rst_n = 0, out_ready = 0;
  logic [15:0] req_valid = '0, req_last = '0, req_ready, grant;
  logic [16*DW-1:0] req_data = '0;
  logic out_valid, out_last, busy;
  logic [DW-1:0] out_data;
  logic [3:0] sel;
  int vectors = 0, miscompares = 0;
  bit armed = 0, m_locked = 0;
  int m_sel = 0, m_ptr = 0;
  int seq [4] = '{2, 15, 0, 2};
  always #5 clk = ~clk;
  mux16_rr_arbiter #(.DATA_W(DW), .NUM_REQ(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .grant(grant), .busy(busy)
  );
  function automatic int pick(logic [15:0] v, int p);
    for (int k = 0; k < 16; k++) if (v[(p + k) % 16]) return (p + k) % 16;
    return -1;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    int w;
    if (!rst_n) begin
      armed = 1;
      m_locked = 0;
      m_sel = 0;
      m_ptr = 0;
    end else if (!m_locked) begin
      w = pick(req_valid, m_ptr);
      if (w >= 0) begin
        m_locked = 1;
        m_sel = w;
      end
    end else if (req_valid[m_sel] && out_ready && req_last[m_sel]) begin
      m_ptr = (m_sel + 1) % 16;
      w = pick(req_valid, m_ptr);
      if (w >= 0) m_sel = w;
      else m_locked = 0;
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("grant", 32'(grant), m_locked ? 32'(1) << m_sel : 32'(0));
      chk("sel", 32'(sel), 32'(m_sel));
      chk("busy", 32'(busy), 32'(m_locked));
      chk("out_valid", 32'(out_valid), 32'(m_locked && req_valid[m_sel]));
      chk("req_ready", 32'(req_ready), (m_locked && out_ready) ? 32'(1) << m_sel : 32'(0));
      if (m_locked && req_valid[m_sel]) begin
        chk("out_data", 32'(out_data), 32'(req_data[m_sel*DW +: DW]));
        chk("out_last", 32'(out_last), 32'(req_last[m_sel]));
      end
    end
  end
  initial begin
    req_valid = '1;
    out_ready = 1;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1;
    cyc();
    req_valid = 16'h8005;
    req_last = '1;
    @(negedge clk);
    chk("first_grant", 32'(grant), 32'h0001);
    chk("first_sel", 32'(sel), 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      chk("rr_sel", 32'(sel), 32'(seq[i]));
      chk("rr_valid", 32'(out_valid), 1);
    end
    req_valid = 16'h001C;
    req_last = 16'h0004;
    cyc();
    req_valid = 16'h0018;
    req_last = '0;
    req_data[3*DW +: DW] = 8'hA0;
    @(negedge clk);
    chk("mb_sel0", 32'(sel), 3);
    chk("mb_data0", 32'(out_data), 32'hA0);
    cyc();
    req_data[3*DW +: DW] = 8'hA1;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_data", 32'(out_data), 32'hA1);
      chk("bp_sel", 32'(sel), 3);
      chk("bp_ready", 32'(req_ready), 0);
      cyc();
    end
    out_ready = 1;
    @(negedge clk);
    chk("mb_data1", 32'(out_data), 32'hA1);
    chk("mb_ready1", 32'(req_ready), 32'h0008);
    cyc();
    req_data[3*DW +: DW] = 8'hA2;
    @(negedge clk);
    chk("mb_data2", 32'(out_data), 32'hA2);
    cyc();
    req_data[3*DW +: DW] = 8'hA3;
    req_last = 16'h0008;
    @(negedge clk);
    chk("mb_data3", 32'(out_data), 32'hA3);
    chk("mb_last3", 32'(out_last), 1);
    cyc();
    @(negedge clk);
    chk("mb_next_sel", 32'(sel), 4);
    req_valid = 16'h8010;
    req_last = '1;
    cyc();
    req_valid = 16'h8001;
    @(negedge clk);
    chk("wrap_sel15", 32'(sel), 15);
    cyc();
    @(negedge clk);
    chk("wrap_sel0", 32'(sel), 0);
    cyc();
    @(negedge clk);
    chk("wrap_sel15b", 32'(sel), 15);
    req_valid = 16'h8000;
    req_last = '0;
    req_data[15*DW +: DW] = 8'hB0;
    cyc();
    req_data[15*DW +: DW] = 8'hB1;
    @(negedge clk);
    chk("mid_data", 32'(out_data), 32'hB1);
    rst_n = 0;
    cyc();
    rst_n = 1;
    req_valid = 16'h8001;
    req_last = '1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_grant", 32'(grant), 0);
    cyc();
    @(negedge clk);
    chk("restart_sel", 32'(sel), 0);
    chk("restart_grant", 32'(grant), 32'h0001);
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst_n = $urandom_range(99) != 0;
      req_valid = 16'($urandom) & 16'($urandom | $urandom);
      req_last = 16'($urandom);
      for (int k = 0; k < 16; k++) req_data[k*DW +: DW] = 8'($urandom);
      out_ready = $urandom_range(3) != 0;
    end
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 16:1 multiplexer.
- 16 requesters each present a packet stream. The block grants one requester at a time, drives the 4-bit mux select, and forwards the granted stream with a valid/ready handshake.
- The grant is locked for a whole packet and released on the accepted last beat.
- Sits between 16 producer channels and a single downstream consumer.

Parameters:
- DATA_W, 8, width of each requester's data beat.
- NUM_REQ, 16, number of requesters. Fixed at 16; the select width is 4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on clk rising edge
- req_valid  input  16  per-requester beat valid
- req_data  input  16*DATA_W  flattened data; requester k occupies bits [k*DATA_W +: DATA_W]
- req_last  input  16  per-requester last-beat flag
- req_ready  output  16  per-requester ready; at most one bit high
- out_valid  output  1  forwarded valid
- out_data  output  DATA_W  forwarded data (muxed by sel)
- out_last  output  1  forwarded last flag
- out_ready  input  1  downstream ready
- sel  output  4  current mux select (index of granted requester)
- grant  output  16  one-hot registered grant, zero when idle
- busy  output  1  high while a packet is in progress (state LOCKED)

Behaviour:
- States: IDLE, LOCKED. Registers: state, sel, grant, ptr[3:0] (index with highest priority on the next arbitration).
- Reset, when rst_n=0 at a clk edge:
  - state=IDLE, sel=0, grant=0, ptr=0, busy=0.
  - Combinationally, out_valid=0 and req_ready=0 while state=IDLE.
  - Reset overrides everything, including a packet in progress. No partial-packet completion; the consumer sees out_valid drop the cycle after reset is sampled.
- Arbitration (combinational): pick the first set bit of req_valid scanning ptr, ptr+1, ..., ptr+15, modulo 16 (wrap 15->0).
- IDLE:
  - If any req_valid bit is set, the next edge loads sel/grant with the winner and enters LOCKED.
  - Arbitration latency is 1 cycle: no data moves in the IDLE cycle.
- LOCKED:
  - out_valid = req_valid[sel]; out_data = req_data[sel]; out_last = req_last[sel].
  - req_ready[sel] = out_ready; all other req_ready bits are 0.
  - Beat accepted when out_valid & out_ready.
  - Accepted beat with out_last=0: stay LOCKED, sel unchanged.
  - Accepted beat with out_last=1:
    - ptr <= sel+1 (mod 16).
    - Re-arbitrate in the same cycle using the pointer value sel+1. The current requester is eligible but has the lowest priority.
    - If a winner exists, load the new sel/grant and stay LOCKED: back-to-back, zero bubble.
    - Otherwise go to IDLE, grant=0, sel holds its last value.
- Mid-packet valid drop: req_valid[sel]=0 inside a packet does not release the grant; the lock holds until the last beat is accepted. Other requesters wait indefinitely, with no timeout.
- Non-granted requesters always see req_ready=0, even if their req_valid is high.
- Single-beat packet (valid and last in the same beat) is legal and releases the grant on acceptance.
- out_ready=0 with out_valid=1: all outputs hold stable and no state change occurs.
- Out of packet, when state=IDLE: out_data and out_last are don't-care; out_valid=0 and req_ready=0.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with req_valid=16'hFFFF -> grant=0, out_valid=0, req_ready=0, sel=0, busy=0. Release reset -> next edge grant=16'h0001, sel=0.
- Round-robin fairness:
  - Setup: req_valid=16'h8005 (reqs 0, 2, 15), each sending single-beat packets, out_ready=1.
  - Required grant order: 0, 2, 15, 0, 2, ... with no idle cycles between grants.
- Multi-beat lock:
  - Setup: req 3 sends 4 beats 8'hA0..8'hA3, last on the 4th; req 4 is valid throughout.
  - Required: sel=3 for all 4 beats, out_data sequence A0, A1, A2, A3; sel=4 on the cycle after the A3 accept.
- Backpressure: hold out_ready=0 for 3 cycles mid-packet -> out_data, sel and req_ready stay stable; no beat lost or duplicated once out_ready=1.
- Wrap-around:
  - Setup: after a packet from req 15 completes, req_valid=16'h8001.
  - Required: grant req 0 next (ptr wrapped to 0), then 15.
- Reset mid-packet: assert rst_n=0 during beat 2 of a 4-beat packet -> next cycle state=IDLE, out_valid=0. After release, arbitration restarts from ptr=0.
